// File: rtl/bp_bimodal_btb_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | bp_bimodal_btb_pkg                                                         |
// | Shared fetch/predict types: fetch packet, branch update packet, decode.    |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
package bp_bimodal_btb_pkg;

   localparam int XLEN = 32;

   typedef struct packed {
      logic [XLEN-1:0] PC;
      logic [XLEN-1:0] NPC;
      logic [31:0]     inst;
      logic            valid;
   } IF_IB_PACKET;

   // Execute will eventually drive training through this single struct.
   typedef struct packed {
      logic            valid;
      logic [XLEN-1:0] pc;
      logic            is_cond;
      logic            taken;
      logic [XLEN-1:0] target;
   } BP_UPD_PACKET;

   typedef struct packed {
      logic cond_branch;
      logic uncond_branch;
      logic jump;
      logic link;
   } PD_CLASS;

   localparam logic [6:0] c_op_branch = 7'b1100011;
   localparam logic [6:0] c_op_jal    = 7'b1101111;
   localparam logic [6:0] c_op_jalr   = 7'b1100111;

   // Weakly not-taken: all ones below the MSB.
   function automatic int unsigned ctr_init(input int unsigned bits);
      return (32'd1 << (bits - 1)) - 32'd1;
   endfunction

   localparam int unsigned c_ctr_init_default = ctr_init(2);

endpackage
`default_nettype wire

// File: rtl/bp_bimodal_btb_pre_decode.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | bp_bimodal_btb_pre_decode                                                  |
// | Classifies a fetched RV32 instruction for branch prediction.               |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module bp_bimodal_btb_pre_decode
   import bp_bimodal_btb_pkg::*;
(
   input  logic [31:0] i_inst,
   output PD_CLASS     o_class
);

   logic [6:0] w_opcode;
   logic [4:0] w_rd;
   logic [4:0] w_rs1;
   logic       w_rd_link;
   logic       w_rs1_link;
   logic       w_unused;

   assign w_opcode   = i_inst[6:0];
   assign w_rd       = i_inst[11:7];
   assign w_rs1      = i_inst[19:15];
   // x1 and x5 are the ABI link registers.
   assign w_rd_link  = (w_rd == 5'd1) || (w_rd == 5'd5);
   assign w_rs1_link = (w_rs1 == 5'd1) || (w_rs1 == 5'd5);

   always_comb begin
      o_class               = '0;
      o_class.cond_branch   = (w_opcode == c_op_branch);
      o_class.uncond_branch = (w_opcode == c_op_jal);
      o_class.jump          = (w_opcode == c_op_jalr);
      o_class.link          = ((w_opcode == c_op_jal) && w_rd_link) ||
                              ((w_opcode == c_op_jalr) && (w_rd_link || w_rs1_link));
   end

   assign w_unused = ^{i_inst[31:20], i_inst[14:12]};

endmodule
`default_nettype wire

// File: rtl/bp_bimodal_btb.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | bp_bimodal_btb                                                             |
// | Bimodal PHT of saturating counters plus direct-mapped tagged BTB.          |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module bp_bimodal_btb
   import bp_bimodal_btb_pkg::*;
#(
   parameter int PHT_ENTRIES = 64,
   parameter int BTB_ENTRIES = 16,
   parameter int TAG_BITS    = 8,
   parameter int CTR_BITS    = 2
)(
   input  logic            clock,
   input  logic            reset,
   input  IF_IB_PACKET     if_ib_packet,
   input  logic            upd_valid,
   input  logic [XLEN-1:0] upd_pc,
   input  logic            upd_is_cond,
   input  logic            upd_taken,
   input  logic [XLEN-1:0] upd_target,
   output logic [XLEN-1:0] bp_pc,
   output logic [XLEN-1:0] bp_npc,
   output logic            bp_taken
);

   localparam int c_pht_idx = $clog2(PHT_ENTRIES);
   localparam int c_btb_idx = $clog2(BTB_ENTRIES);
   localparam logic [CTR_BITS-1:0] c_ctr_init = CTR_BITS'(ctr_init(CTR_BITS));
   localparam logic [CTR_BITS-1:0] c_ctr_max  = '1;

   logic [CTR_BITS-1:0] r_pht        [PHT_ENTRIES];
   logic [BTB_ENTRIES-1:0] r_btb_valid;
   logic [TAG_BITS-1:0] r_btb_tag    [BTB_ENTRIES];
   logic [XLEN-1:0]     r_btb_target [BTB_ENTRIES];

   PD_CLASS              w_cls;
   logic [c_pht_idx-1:0] w_pht_i;
   logic [c_btb_idx-1:0] w_btb_i;
   logic [TAG_BITS-1:0]  w_tag;
   logic                 w_hit;
   logic                 w_dir;
   logic [c_pht_idx-1:0] w_upd_pht_i;
   logic [c_btb_idx-1:0] w_upd_btb_i;
   logic [TAG_BITS-1:0]  w_upd_tag;
   logic [CTR_BITS-1:0]  w_ctr_cur;
   logic [CTR_BITS-1:0]  w_ctr_next;
   logic                 w_unused;

   bp_bimodal_btb_pre_decode u_pre_decode (
      .i_inst  (if_ib_packet.inst),
      .o_class (w_cls)
   );

   assign w_pht_i = if_ib_packet.PC[c_pht_idx+1:2];
   assign w_btb_i = if_ib_packet.PC[c_btb_idx+1:2];
   assign w_tag   = if_ib_packet.PC[2+c_btb_idx +: TAG_BITS];

   assign w_hit   = r_btb_valid[w_btb_i] && (r_btb_tag[w_btb_i] == w_tag);
   // JALR is never redirected here: its target comes from a register, not the BTB.
   assign w_dir   = w_cls.uncond_branch || (w_cls.cond_branch && r_pht[w_pht_i][CTR_BITS-1]);

   assign bp_pc    = if_ib_packet.PC;
   assign bp_taken = if_ib_packet.valid && w_hit && w_dir;
   assign bp_npc   = bp_taken ? r_btb_target[w_btb_i] : if_ib_packet.NPC;

   assign w_upd_pht_i = upd_pc[c_pht_idx+1:2];
   assign w_upd_btb_i = upd_pc[c_btb_idx+1:2];
   assign w_upd_tag   = upd_pc[2+c_btb_idx +: TAG_BITS];
   assign w_ctr_cur   = r_pht[w_upd_pht_i];

   always_comb begin
      w_ctr_next = w_ctr_cur;
      if (upd_taken && (w_ctr_cur != c_ctr_max))
         w_ctr_next = w_ctr_cur + CTR_BITS'(1);
      else if (!upd_taken && (w_ctr_cur != '0))
         w_ctr_next = w_ctr_cur - CTR_BITS'(1);
   end

   always_ff @(posedge clock) begin
      if (!reset) begin
         for (int i = 0; i < PHT_ENTRIES; i++)
            r_pht[i] <= c_ctr_init;
         r_btb_valid <= '0;
      end else if (upd_valid) begin
         if (upd_is_cond)
            r_pht[w_upd_pht_i] <= w_ctr_next;
         if (upd_taken)
            r_btb_valid[w_upd_btb_i] <= 1'b1;
      end
   end

   // Tags and targets are qualified by r_btb_valid, so they carry no reset.
   always_ff @(posedge clock) begin
      if (reset && upd_valid && upd_taken) begin
         r_btb_tag[w_upd_btb_i]    <= w_upd_tag;
         r_btb_target[w_upd_btb_i] <= upd_target;
      end
   end

   assign w_unused = ^{if_ib_packet.PC, upd_pc, w_cls.jump, w_cls.link};

endmodule
`default_nettype wire

// File: tb/tb_bp_bimodal_btb.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_bp_bimodal_btb                                                          |
// | Scoreboard bench for the bimodal predictor (2-bit and 3-bit counters).     |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_bp_bimodal_btb;
   import bp_bimodal_btb_pkg::*;

   localparam logic [31:0] c_beq  = 32'h0000_0063;
   localparam logic [31:0] c_jal  = 32'h0000_00EF;
   localparam logic [31:0] c_jalr = 32'h0000_8067;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] npc;
      logic [31:0] npc3;
      logic        t;
      logic        t3;
   } exp_t;

   logic        clock;
   logic        reset;
   IF_IB_PACKET pkt;
   logic        upd_valid;
   logic [31:0] upd_pc;
   logic        upd_is_cond;
   logic        upd_taken;
   logic [31:0] upd_target;
   logic [31:0] bp_pc, bp_npc, bp_pc3, bp_npc3;
   logic        bp_taken, bp_taken3;

   int unsigned m_ctr2 [64];
   int unsigned m_ctr3 [64];
   bit          m_v    [16];
   logic [7:0]  m_tag  [16];
   logic [31:0] m_tgt  [16];
   exp_t        q [$];
   int          n_total;
   int          n_bad;

   bp_bimodal_btb u_dut (
      .clock(clock), .reset(reset), .if_ib_packet(pkt),
      .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_is_cond(upd_is_cond),
      .upd_taken(upd_taken), .upd_target(upd_target),
      .bp_pc(bp_pc), .bp_npc(bp_npc), .bp_taken(bp_taken)
   );

   bp_bimodal_btb #(.CTR_BITS(3)) u_dut3 (
      .clock(clock), .reset(reset), .if_ib_packet(pkt),
      .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_is_cond(upd_is_cond),
      .upd_taken(upd_taken), .upd_target(upd_target),
      .bp_pc(bp_pc3), .bp_npc(bp_npc3), .bp_taken(bp_taken3)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got=%h expected=%h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic void model_reset();
      for (int i = 0; i < 64; i++) begin
         m_ctr2[i] = 1;
         m_ctr3[i] = 3;
      end
      for (int i = 0; i < 16; i++) m_v[i] = 1'b0;
   endfunction

   function automatic exp_t predict(input logic fv, input logic [31:0] pc, input logic [31:0] inst);
      exp_t e;
      logic hit, cond, unc;
      hit  = m_v[pc[5:2]] && (m_tag[pc[5:2]] == pc[13:6]);
      cond = (inst[6:0] == 7'h63);
      unc  = (inst[6:0] == 7'h6F);
      e.pc   = pc;
      e.t    = fv && hit && (unc || (cond && m_ctr2[pc[7:2]] >= 2));
      e.t3   = fv && hit && (unc || (cond && m_ctr3[pc[7:2]] >= 4));
      e.npc  = e.t  ? m_tgt[pc[5:2]] : pc + 32'd4;
      e.npc3 = e.t3 ? m_tgt[pc[5:2]] : pc + 32'd4;
      return e;
   endfunction

   function automatic void model_update(input bit rn, input bit uv, input logic [31:0] upc,
                                        input bit uc, input bit ut, input logic [31:0] utg);
      if (!rn) begin
         model_reset();
      end else if (uv) begin
         if (uc) begin
            if (ut) begin
               if (m_ctr2[upc[7:2]] < 3) m_ctr2[upc[7:2]]++;
               if (m_ctr3[upc[7:2]] < 7) m_ctr3[upc[7:2]]++;
            end else begin
               if (m_ctr2[upc[7:2]] > 0) m_ctr2[upc[7:2]]--;
               if (m_ctr3[upc[7:2]] > 0) m_ctr3[upc[7:2]]--;
            end
         end
         if (ut) begin
            m_v[upc[5:2]]   = 1'b1;
            m_tag[upc[5:2]] = upc[13:6];
            m_tgt[upc[5:2]] = utg;
         end
      end
   endfunction

   // w2/w3 < 0 means "no fixed directional expectation for this cycle".
   task automatic cyc(input bit rn, input bit fv, input logic [31:0] pc, input logic [31:0] inst,
                      input bit uv, input logic [31:0] upc, input bit uc, input bit ut,
                      input logic [31:0] utg, input int w2, input int w3);
      exp_t e;
      @(negedge clock);
      reset = rn; pkt.valid = fv; pkt.PC = pc; pkt.NPC = pc + 32'd4; pkt.inst = inst;
      upd_valid = uv; upd_pc = upc; upd_is_cond = uc; upd_taken = ut; upd_target = utg;
      q.push_back(predict(fv, pc, inst));
      #4;
      e = q.pop_front();
      chk("bp_pc",     bp_pc,            e.pc);
      chk("bp_npc",    bp_npc,           e.npc);
      chk("bp_taken",  32'(bp_taken),    32'(e.t));
      chk("bp_pc3",    bp_pc3,           e.pc);
      chk("bp_npc3",   bp_npc3,          e.npc3);
      chk("bp_taken3", 32'(bp_taken3),   32'(e.t3));
      if (w2 >= 0) chk("dir2_fixed", 32'(bp_taken),  32'(w2));
      if (w3 >= 0) chk("dir3_fixed", 32'(bp_taken3), 32'(w3));
      @(posedge clock);
      model_update(rn, uv, upc, uc, ut, utg);
   endtask

   function automatic logic [31:0] pick_pc(input int k);
      case (k)
         0:       return 32'h100;
         1:       return 32'h140;
         2:       return 32'h180;
         3:       return 32'h200;
         default: return 32'h1C4;
      endcase
   endfunction

   initial begin
      n_total = 0; n_bad = 0;
      reset = 1'b0; pkt = '0; upd_valid = 1'b0; upd_pc = '0;
      upd_is_cond = 1'b0; upd_taken = 1'b0; upd_target = '0;
      model_reset();
      repeat (2) @(posedge clock);

      // Reset cycle with a training request that must be dropped.
      cyc(0, 1, 32'h100, c_beq, 1, 32'h100, 1, 1, 32'h80, 0, 0);
      cyc(1, 1, 32'h100, c_beq, 0, 0, 0, 0, 0, 0, 0);
      chk("npc_reset", bp_npc, 32'h104);

      // Same-cycle update and lookup sees the old state.
      cyc(1, 1, 32'h100, c_beq, 1, 32'h100, 1, 1, 32'h80, 0, 0);
      cyc(1, 1, 32'h100, c_beq, 0, 0, 0, 0, 0, 1, 1);
      repeat (4) cyc(1, 0, 32'h100, c_beq, 1, 32'h100, 1, 1, 32'h80, 0, 0);
      cyc(1, 1, 32'h100, c_beq, 0, 0, 0, 0, 0, 1, 1);
      repeat (2) cyc(1, 1, 32'h100, c_beq, 1, 32'h100, 1, 0, 0, 1, 1);
      cyc(1, 1, 32'h100, c_beq, 0, 0, 0, 0, 0, 0, 1);

      // Underflow on the 2-bit counter, then overflow on the 3-bit one.
      repeat (3) cyc(1, 0, 32'h100, c_beq, 1, 32'h100, 1, 0, 0, 0, 0);
      cyc(1, 1, 32'h100, c_beq, 1, 32'h100, 1, 1, 32'h80, 0, 0);
      cyc(1, 1, 32'h100, c_beq, 1, 32'h100, 1, 1, 32'h80, 0, 0);
      cyc(1, 1, 32'h100, c_beq, 0, 0, 0, 0, 0, 1, 1);
      repeat (6) cyc(1, 0, 32'h100, c_beq, 1, 32'h100, 1, 1, 32'h80, 0, 0);
      repeat (3) cyc(1, 0, 32'h100, c_beq, 1, 32'h100, 1, 0, 0, 0, 0);
      cyc(1, 1, 32'h100, c_beq, 0, 0, 0, 0, 0, 0, 1);

      // BTB alias: 0x140 shares the BTB slot with 0x100 under a different tag.
      cyc(1, 0, 32'h100, c_beq, 1, 32'h140, 0, 1, 32'h200, 0, 0);
      cyc(1, 1, 32'h100, c_beq, 0, 0, 0, 0, 0, 0, 0);
      cyc(1, 1, 32'h140, c_jal, 0, 0, 0, 0, 0, 1, 1);
      chk("alias_npc", bp_npc, 32'h200);

      // JALR is trained into the BTB but never predicted.
      repeat (2) cyc(1, 1, 32'h180, c_jalr, 1, 32'h180, 0, 1, 32'h300, 0, 0);
      cyc(1, 1, 32'h180, c_jalr, 0, 0, 0, 0, 0, 0, 0);

      // Mid-stream reset discards all training.
      cyc(0, 0, 32'h140, c_jal, 0, 0, 0, 0, 0, 0, 0);
      cyc(1, 1, 32'h140, c_jal, 0, 0, 0, 0, 0, 0, 0);
      cyc(1, 1, 32'h100, c_beq, 0, 0, 0, 0, 0, 0, 0);

      for (int i = 0; i < 120; i++) begin
         logic [31:0] ins;
         case ($urandom_range(0, 2))
            0:       ins = c_beq;
            1:       ins = c_jal;
            default: ins = c_jalr;
         endcase
         cyc(($urandom_range(0, 39) != 0), 1'($urandom_range(0, 3) != 0),
             pick_pc($urandom_range(0, 4)), ins,
             1'($urandom_range(0, 1)), pick_pc($urandom_range(0, 4)),
             1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
             32'($urandom_range(0, 255)) << 2, -1, -1);
      end

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
`default_nettype wire
